// File: rtl/fb_pixel_writer_pkg.sv
// Shared render constants and the framebuffer write record.
//   H_RES/V_RES : visible resolution (H_RES is also the row stride)
//   CORDW/COLRW : coordinate and colour-index widths
//   ADDRW       : framebuffer address width
//   DEPTH/CNTW  : default write FIFO depth and statistics counter width
//   fb_wr_t     : one pending framebuffer write {addr, colr}
package fb_pixel_writer_pkg;

    localparam int CORDW = 10;
    localparam int COLRW = 4;
    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int ADDRW = 19;
    localparam int DEPTH = 4;
    localparam int CNTW  = 16;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [COLRW-1:0] colr;
    } fb_wr_t;

endpackage

// File: rtl/fb_pixel_writer_fifo.sv
// pix_fifo: synchronous show-ahead FIFO.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : write din_i (accepted when not full, or when popping same edge)
//   din_i      : data in
//   pop_i      : drop the head (ignored when empty)
//   dout_o     : head entry, valid while !empty_o
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   count_o    : entries held, 0..DEPTH
module pix_fifo
    import fb_pixel_writer_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fb_wr_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  T                         din_i,
    input  logic                     pop_i,
    output T                         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    T             mem_q [DEPTH];
    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Pointers carry one extra bit so full and empty differ; wrap is modulo 2*DEPTH.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (count_o == (PW+1)'(DEPTH));
    assign dout_o  = mem_q[rd_ptr_q[PW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: clips renderer pixel strobes to the screen, converts them to
// linear framebuffer addresses and queues them toward an arbitrated write port.
//   clk, rst        : clock, synchronous active-high reset
//   px_valid/ready  : pixel handshake; px_ready drives the iterators' oe
//   px_x/px_y/colr  : pixel coordinate and colour
//   mem_req/grant   : head write pending / arbiter grant (commit on req && grant)
//   mem_addr/data   : head write address and colour
//   clr_stats       : zero both counters (wins over a same-edge increment)
//   idle            : stage register and FIFO both empty
//   n_written       : committed writes, saturating
//   n_clipped       : dropped off-screen pixels, saturating
module fb_pixel_writer #(
    parameter int CORDW = fb_pixel_writer_pkg::CORDW,
    parameter int COLRW = fb_pixel_writer_pkg::COLRW,
    parameter int H_RES = fb_pixel_writer_pkg::H_RES,
    parameter int V_RES = fb_pixel_writer_pkg::V_RES,
    parameter int ADDRW = fb_pixel_writer_pkg::ADDRW,
    parameter int DEPTH = fb_pixel_writer_pkg::DEPTH,
    parameter int CNTW  = fb_pixel_writer_pkg::CNTW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             px_valid,
    output logic             px_ready,
    input  logic [CORDW-1:0] px_x,
    input  logic [CORDW-1:0] px_y,
    input  logic [COLRW-1:0] px_colr,
    output logic             mem_req,
    input  logic             mem_grant,
    output logic [ADDRW-1:0] mem_addr,
    output logic [COLRW-1:0] mem_data,
    input  logic             clr_stats,
    output logic             idle,
    output logic [CNTW-1:0]  n_written,
    output logic [CNTW-1:0]  n_clipped
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [COLRW-1:0] colr;
    } wr_t;

    logic             stage_v_q, stage_v_d;
    wr_t              stage_q, stage_d;
    logic [CNTW-1:0]  n_written_q, n_written_d;
    logic [CNTW-1:0]  n_clipped_q, n_clipped_d;

    logic             fifo_full, fifo_empty;
    logic [PW:0]      fifo_count;
    wr_t              head;

    logic             accept, in_bounds, pop;
    logic [ADDRW-1:0] lin_addr;

    // Occupancy (FIFO + stage) must stay below DEPTH so a staged pixel always
    // has a slot; registers only, no path from px_valid or mem_grant.
    assign px_ready = !rst && !fifo_full &&
                      !(stage_v_q && (fifo_count == (PW+1)'(DEPTH - 1)));

    assign accept    = px_valid && px_ready;
    assign in_bounds = (int'(px_x) < H_RES) && (int'(px_y) < V_RES);
    assign lin_addr  = ADDRW'(px_y) * ADDRW'(H_RES) + ADDRW'(px_x);

    assign mem_req  = !fifo_empty;
    assign pop      = mem_req && mem_grant;
    assign mem_addr = head.addr;
    assign mem_data = head.colr;
    assign idle     = !stage_v_q && fifo_empty;

    assign n_written = n_written_q;
    assign n_clipped = n_clipped_q;

    always_comb begin
        stage_v_d = accept && in_bounds;
        stage_d   = stage_q;
        if (accept) begin
            stage_d.addr = lin_addr;
            stage_d.colr = px_colr;
        end
    end

    always_comb begin
        n_written_d = n_written_q;
        n_clipped_d = n_clipped_q;
        if (clr_stats) begin
            n_written_d = '0;
            n_clipped_d = '0;
        end else begin
            if (pop && (n_written_q != '1))
                n_written_d = n_written_q + 1'b1;
            if (accept && !in_bounds && (n_clipped_q != '1))
                n_clipped_d = n_clipped_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_v_q   <= 1'b0;
            n_written_q <= '0;
            n_clipped_q <= '0;
        end else begin
            stage_v_q   <= stage_v_d;
            n_written_q <= n_written_d;
            n_clipped_q <= n_clipped_d;
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    pix_fifo #(
        .DEPTH (DEPTH),
        .T     (wr_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (stage_v_q),
        .din_i   (stage_q),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_fb_pixel_writer.sv
module tb_fb_pixel_writer;

    localparam int H     = 640;
    localparam int V     = 480;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        px_valid;
    logic        px_ready;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic [3:0]  px_colr;
    logic        mem_req;
    logic        mem_grant;
    logic [18:0] mem_addr;
    logic [3:0]  mem_data;
    logic        clr_stats;
    logic        idle;
    logic [15:0] n_written;
    logic [15:0] n_clipped;

    int checks   = 0;
    int failures = 0;

    // Reference model: ordered list of expected writes plus expected counter values.
    int          exp_addr_q [$];
    logic [3:0]  exp_colr_q [$];
    int          exp_written = 0;
    int          exp_clip    = 0;
    bit          rand_grant  = 0;

    fb_pixel_writer dut (
        .clk       (clk),
        .rst       (rst),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_colr   (px_colr),
        .mem_req   (mem_req),
        .mem_grant (mem_grant),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .clr_stats (clr_stats),
        .idle      (idle),
        .n_written (n_written),
        .n_clipped (n_clipped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every write that commits must be the oldest outstanding accepted on-screen pixel.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_grant) begin
            if (exp_addr_q.size() == 0) begin
                chk("wr_unexpected", 32'(exp_addr_q.size()), 32'd1);
            end else begin
                chk("wr_addr", 32'(mem_addr), 32'(exp_addr_q[0]));
                chk("wr_data", 32'(mem_data), 32'(exp_colr_q[0]));
                void'(exp_addr_q.pop_front());
                void'(exp_colr_q.pop_front());
                exp_written++;
            end
        end
    end

    task automatic model_accept(input int x, input int y, input logic [3:0] c);
        if (x < H && y < V) begin
            exp_addr_q.push_back(y * H + x);
            exp_colr_q.push_back(c);
        end else begin
            exp_clip++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (rand_grant) mem_grant = 1'($urandom_range(0, 1));
    endtask

    // Present one pixel and hold it until accepted (bounded).
    task automatic send(input int x, input int y, input logic [3:0] c);
        int waited = 0;
        px_valid = 1'b1;
        px_x     = 10'(x);
        px_y     = 10'(y);
        px_colr  = c;
        forever begin
            @(negedge clk);
            if (px_ready) begin
                model_accept(x, y, c);
                next_cycle();
                break;
            end
            if (waited >= 300) begin
                chk("accept_timeout", 32'(px_ready), 32'd1);
                break;
            end
            next_cycle();
            waited++;
        end
        px_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        rand_grant = 0;
        mem_grant  = 1'b1;
        px_valid   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_addr_q.size() == 0 && idle) break;
        end
        chk({tag, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(idle), 32'd1);
        chk({tag, "_n_written"}, 32'(n_written), 32'(exp_written));
        chk({tag, "_n_clipped"}, 32'(n_clipped), 32'(exp_clip));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        px_valid  = 1'b0;
        px_x      = '0;
        px_y      = '0;
        px_colr   = '0;
        mem_grant = 1'b0;
        clr_stats = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_low", 32'(px_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(px_ready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_n_written", 32'(n_written), 32'd0);
        chk("rst_n_clipped", 32'(n_clipped), 32'd0);

        // Single pixel latency: accept in cycle t, request in t+2, idle in t+3
        @(posedge clk);
        #1;
        mem_grant = 1'b1;
        px_valid  = 1'b1;
        px_x      = 10'd5;
        px_y      = 10'd2;
        px_colr   = 4'hA;
        @(negedge clk);
        chk("t1_ready", 32'(px_ready), 32'd1);
        model_accept(5, 2, 4'hA);
        @(posedge clk);
        #1;
        px_valid = 1'b0;
        @(negedge clk);
        chk("t1_req_t1", 32'(mem_req), 32'd0);
        chk("t1_idle_t1", 32'(idle), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_req_t2", 32'(mem_req), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'd1285);
        chk("t1_data", 32'(mem_data), 32'hA);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_idle_t3", 32'(idle), 32'd1);
        chk("t1_n_written", 32'(n_written), 32'd1);

        // Back-to-back stream with grant held: never stalls
        @(posedge clk);
        #1;
        for (int x = 0; x < 10; x++) begin
            logic [3:0] c;
            c        = 4'($urandom);
            px_valid = 1'b1;
            px_x     = 10'(x);
            px_y     = 10'd0;
            px_colr  = c;
            @(negedge clk);
            chk("t2_ready", 32'(px_ready), 32'd1);
            if (px_ready) model_accept(x, 0, c);
            @(posedge clk);
            #1;
        end
        px_valid = 1'b0;
        drain("t2");

        // Grant withheld for 20 cycles: exactly DEPTH pixels accepted, then stall
        mem_grant = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic [3:0] c;
            c        = 4'($urandom);
            px_valid = 1'b1;
            px_x     = 10'(k);
            px_y     = 10'd3;
            px_colr  = c;
            @(negedge clk);
            chk("t3_ready", 32'(px_ready), 32'(k < DEPTH));
            if (px_ready) begin
                model_accept(k, 3, c);
                k++;
            end
            @(posedge clk);
            #1;
        end
        chk("t3_accepted", 32'(k), 32'(DEPTH));
        px_valid  = 1'b0;
        mem_grant = 1'b1;
        for (int x = k; x < 8; x++) send(x, 3, 4'($urandom));
        drain("t3");

        // Clip boundaries
        send(640, 0, 4'h1);
        send(0, 480, 4'h2);
        send(639, 479, 4'h3);
        drain("t4");

        // Fill to capacity, then release grant while continuing to stream
        mem_grant = 1'b0;
        for (int x = 0; x < DEPTH; x++) send(x, 7, 4'($urandom));
        @(negedge clk);
        chk("t5_full_ready", 32'(px_ready), 32'd0);
        @(posedge clk);
        #1;
        mem_grant = 1'b1;
        for (int x = DEPTH; x < DEPTH + 12; x++) send(x, 7, 4'($urandom));
        drain("t5");

        // Randomized pixels, some off-screen, with random grant
        rand_grant = 1;
        for (int i = 0; i < 60; i++)
            send(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 4'($urandom));
        drain("rnd");

        // clr_stats wins over a same-edge commit
        mem_grant = 1'b0;
        send(11, 11, 4'h5);
        repeat (2) next_cycle();
        mem_grant = 1'b1;
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        exp_written = 0;
        exp_clip    = 0;
        @(negedge clk);
        chk("clr_n_written", 32'(n_written), 32'd0);
        chk("clr_n_clipped", 32'(n_clipped), 32'd0);
        drain("clr");

        // Reset with writes pending discards them
        mem_grant = 1'b0;
        send(1, 1, 4'h1);
        send(2, 1, 4'h2);
        send(3, 1, 4'h3);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_ready_in_rst", 32'(px_ready), 32'd0);
        exp_addr_q.delete();
        exp_colr_q.delete();
        exp_written = 0;
        exp_clip    = 0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_grant = 1'b1;
        @(negedge clk);
        chk("t6_mem_req", 32'(mem_req), 32'd0);
        chk("t6_idle", 32'(idle), 32'd1);
        chk("t6_n_written", 32'(n_written), 32'd0);
        chk("t6_n_clipped", 32'(n_clipped), 32'd0);
        chk("t6_ready", 32'(px_ready), 32'd1);
        @(posedge clk);
        #1;
        send(639, 0, 4'h9);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
